hi_lo_muldiv_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers, in the EX stage beside the ALU. It consumes operands and a decoded op from the ID/EX pipeline register, runs MULT/MULTU/DIV/DIVU over 33 cycles, and raises `busy` so the hazard unit stalls IF/ID/EX. Its `hi`/`lo` outputs feed the ID-stage `hi_signal`/`lo_signal` inputs used by MFHI/MFLO.

---
 rtl/hi_lo_muldiv_unit.sv | 154 +++++++++++++++
 tb/tb_hi_lo_muldiv_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/hi_lo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers, plus MTHI/MTLO writes.
// Latency: mul/div results land 33 edges after the start edge; MTHI/MTLO are visible one cycle after start.
// Backpressure: busy is high through RUN/FIX; start is ignored while busy, flush aborts without writing HI/LO.
module hi_lo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [4:0]         count_q;
  logic               is_div_q;     // 1 = divide, 0 = multiply
  logic               neg_q;        // product / quotient must be negated
  logic               rs_neg_q;     // dividend was negative (remainder sign)
  logic               div0_q;       // divisor was zero
  logic [2*WIDTH-1:0] acc_q;        // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   opnd_q;       // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   rs_raw_q;     // raw dividend, returned in HI on divide by zero
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic               accept, mt_wr;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;
  logic [WIDTH+1:0]   div_trial;
  logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;

  // flush always wins over a same-cycle start; ops 110/111 are no-ops
  assign accept = (state_q == S_IDLE) && start && !flush && !op[2];
  assign mt_wr  = (state_q == S_IDLE) && start && !flush && (op[2:1] == 2'b10);

  // Signed ops iterate on magnitudes; the signs are re-applied in FIX
  assign a_neg = ~op[0] & rs_val[WIDTH-1];
  assign b_neg = ~op[0] & rt_val[WIDTH-1];
  assign a_mag = a_neg ? (~rs_val + 1'b1) : rs_val;
  assign b_mag = b_neg ? (~rt_val + 1'b1) : rt_val;

  // Shift-add step (LSB-first) and restoring-divide step (MSB-first)
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign mul_next  = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
  assign div_trial = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd_q};
  assign div_next  = div_trial[WIDTH+1] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  // Sign correction of the final accumulator
  assign prod = neg_q ? (~acc_q + 1'b1) : acc_q;
  assign quo  = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  assign rem  = rs_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

  // Select the HI/LO values written on leaving FIX
  always_comb begin
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div_q) begin
      if (div0_q) begin
        res_hi = rs_raw_q;
        res_lo = '1;
      end else begin
        res_hi = rem;
        res_lo = quo;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: IDLE -> RUN (32 iterations) -> FIX -> IDLE, flush returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (flush) state_d = S_IDLE;
               else if (count_q == 5'd31) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs come straight from registers
  always_comb begin
    busy = (state_q != S_IDLE);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

  // Datapath: operand latch, per-cycle iteration, HI/LO writeback
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q  <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rs_neg_q <= 1'b0;
      div0_q   <= 1'b0;
      acc_q    <= '0;
      opnd_q   <= '0;
      rs_raw_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            count_q  <= '0;
            is_div_q <= op[1];
            neg_q    <= a_neg ^ b_neg;
            rs_neg_q <= a_neg;
            div0_q   <= (rt_val == '0);
            rs_raw_q <= rs_val;
            acc_q    <= op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
            opnd_q   <= op[1] ? b_mag : a_mag;
          end
          if (mt_wr) begin
            if (op[0]) lo_q <= rs_val;
            else       hi_q <= rs_val;
          end
        end
        S_RUN: begin
          acc_q   <= is_div_q ? div_next : mul_next;
          count_q <= count_q + 5'd1;
        end
        S_FIX: begin
          if (!flush) begin
            hi_q   <= res_hi;
            lo_q   <= res_lo;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hi_lo_muldiv_unit.sv
// Self-checking bench for hi_lo_muldiv_unit: directed vectors, scoreboard queue of expected HI/LO.
// The monitor pops one expectation per done pulse; stimulus tasks check latency, busy and MT* effects.
// Any done without a pending expectation is reported as a failure.
module tb_hi_lo_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  hi_lo_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare HI/LO against the scoreboard whenever done is presented
  always @(negedge clk) begin
    if (reset && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got hi=%h lo=%h with no pending op", hi, lo);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({hi, lo} !== e) begin
          errors++;
          $display("FAIL result: got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full mul/div: push expectation, verify 33 busy cycles and a single-cycle done
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    exp_q.push_back({ehi, elo});
    issue(o, a, b);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, 64'(n), 64'd33);
    check({name, "_done"}, 64'(done), 64'd1);
    @(negedge clk);
    check({name, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [31:0] lo_prev;
    int n;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_state", {28'd0, busy, done, 2'b00, hi, lo}, 64'd0);

    run_op("mult_neg3x7",  3'b000, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu_max",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_m1xm1",   3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
    run_op("div_m7_2",     3'b010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_m2",     3'b010, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu_100_7",   3'b011, 32'd100,       32'd7,         32'd2,         32'd14);
    run_op("divu_by0",     3'b011, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF);
    run_op("div_by0",      3'b010, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_ovf",      3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

    // MTHI: visible one cycle after the start edge, never busy, no done
    @(negedge clk);
    start = 1'b1; op = 3'b100; rs_val = 32'hAAAA_0000;
    @(negedge clk);
    start = 1'b0;
    check("mthi_hi", 64'(hi), 64'h0000_0000_AAAA_0000);
    check("mthi_busy_done", {62'd0, busy, done}, 64'd0);

    // MULT flushed on its 10th RUN cycle: HI kept, no done, idle next cycle
    issue(3'b000, 32'd3, 32'd5);
    for (int i = 1; i < 10; i++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_hi", 64'(hi), 64'h0000_0000_AAAA_0000);
    repeat (40) @(negedge clk);
    check("flush_no_done_hi", 64'(hi), 64'h0000_0000_AAAA_0000);

    // flush beats a same-cycle MTHI in IDLE
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'b100; rs_val = 32'h0000_0001;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("idle_flush_mthi", 64'(hi), 64'h0000_0000_AAAA_0000);

    // No-op code 110 leaves everything alone
    lo_prev = lo;
    issue(3'b110, 32'h1111_1111, 32'h2222_2222);
    check("noop", {30'd0, busy, done, hi}, {32'd0, 32'hAAAA_0000});
    check("noop_lo", 64'(lo), 64'(lo_prev));

    // MTLO while busy is ignored; the MULTU result still lands
    exp_q.push_back({32'd0, 32'd15});
    issue(3'b001, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    lo_prev = lo;
    start = 1'b1; op = 3'b101; rs_val = 32'h0000_0055;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mtlo_busy_ignored", 64'(lo), 64'(lo_prev));
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("mtlo_busy_done", 64'(done), 64'd1);
    @(negedge clk);
    check("mtlo_busy_lo", 64'(lo), 64'd15);

    // Reset mid-DIV clears everything and the divide never completes
    issue(3'b010, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("reset_mid_div", {28'd0, busy, done, 2'b00, hi, lo}, 64'd0);
    repeat (40) @(negedge clk);
    check("reset_no_done", {hi, lo}, 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
